// File: rtl/vga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_gen: VGA raster timing master with look-ahead pixel requests.
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int PIX_LAT = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [9:0] V_LAST      = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_DISP);
  localparam logic [9:0] H_REQ_START = 10'(H_SYNC + H_BACK - PIX_LAT);
  localparam logic [9:0] H_REQ_END   = 10'(H_SYNC + H_BACK + H_DISP - PIX_LAT);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_act;
  logic       v_act;
  logic       h_req;
  logic       active;

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign h_act  = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
  assign v_act  = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
  assign active = h_act && v_act;

  // Requests lead the active window by PIX_LAT so the answer lands on its display clock.
  assign h_req      = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
  assign pixel_xpos = (h_req && v_act) ? (h_cnt - H_REQ_START) : 10'd0;
  assign pixel_ypos = (h_req && v_act) ? (v_cnt - V_ACT_START) : 10'd0;

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      vga_rgb     <= 16'h0000;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= ~(h_cnt < H_SYNC_END);
      vga_vs      <= ~(v_cnt < V_SYNC_END);
      vga_de      <= active;
      vga_rgb     <= active ? pixel_data : 16'h0000;
      frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

endmodule
`default_nettype wire
